// File: rtl/sync_meter_pkg.sv
// sync_meter_pkg: shared types and constants for the video-sync timing meter.
// The optional build macro SYNC_METER_TOL_EN (used by sync_axis_meter) relaxes
// period matching to +/-1 clock/line.
package sync_meter_pkg;

    // Per-axis match state: searching for stable timing, or locked onto it.
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } axis_state_t;

    // Smallest meaningful lock depth: one reference period plus one agreeing period.
    localparam int LOCK_N_MIN = 2;

    // Out-of-range lock depths are pulled up to the minimum rather than
    // producing a zero-width match counter.
    function automatic int clampLockN(input int n);
        return (n < LOCK_N_MIN) ? LOCK_N_MIN : n;
    endfunction

endpackage

// File: rtl/sync_meter_axis.sv
// sync_axis_meter: one axis of the sync meter. Counts ticks between begin
// edges, measures period and pulse width, and locks after LOCK_N agreeing
// periods. Build macro SYNC_METER_TOL_EN: periods agree within +/-1.
module sync_axis_meter
    import sync_meter_pkg::*;
#(
    parameter int W      = 12,
    parameter int LOCK_N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_beg,
    input  logic         i_end,
    input  logic         i_tick,
    output logic [W-1:0] o_period,
    output logic [W-1:0] o_width,
    output logic         o_lock,
    output logic         o_ovf
);

    localparam int LN   = clampLockN(LOCK_N);
    localparam int MC_W = $clog2(LN);
    localparam logic [MC_W-1:0] MC_MAX = MC_W'(LN - 1);

    logic [W-1:0]    r_cnt;
    logic [W-1:0]    r_prev;
    logic [W-1:0]    r_period;
    logic [W-1:0]    r_width;
    logic            r_armed;
    logic            r_havePrev;
    logic [MC_W-1:0] r_mcnt;
    axis_state_t     r_state;
    axis_state_t     w_nextState;

    logic [W-1:0]    w_meas;
    logic [MC_W-1:0] w_mcntNext;
    logic            w_sat;
    logic            w_valid;
    logic            w_perEv;
    logic            w_close;
    logic            w_match;
    logic            w_reach;
    logic            w_lock;
    logic            w_pubPeriod;
    logic            w_pubWidth;

    // The tick of the closing cycle belongs to the interval being measured.
    assign w_sat   = &r_cnt;
    assign w_valid = ~w_sat;
    assign w_meas  = r_cnt + W'(i_tick);
    assign w_perEv = i_beg & r_armed;

`ifdef SYNC_METER_TOL_EN
    logic [W-1:0] w_diff;
    assign w_diff  = (w_meas >= r_prev) ? (w_meas - r_prev) : (r_prev - w_meas);
    assign w_close = (w_diff <= W'(1));
`else
    assign w_close = (w_meas == r_prev);
`endif

    assign w_match    = w_valid & r_havePrev & w_close;
    assign w_mcntNext = w_match ? ((r_mcnt == MC_MAX) ? r_mcnt : r_mcnt + 1'b1) : '0;
    assign w_reach    = w_match & (w_mcntNext == MC_MAX);

    // Interval counter: restart on begin, otherwise count ticks and stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_beg) begin
            r_cnt <= '0;
        end else if (i_tick && !w_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Period history: the first begin only arms; saturated periods break the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed    <= 1'b0;
            r_havePrev <= 1'b0;
            r_prev     <= '0;
            r_mcnt     <= '0;
        end else begin
            if (i_beg) begin
                r_armed <= 1'b1;
            end
            if (w_perEv) begin
                r_mcnt     <= w_mcntNext;
                r_havePrev <= w_valid;
                if (w_valid) begin
                    r_prev <= w_meas;
                end
            end
        end
    end

    // Lock state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= UNLOCKED;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Lock transitions are only evaluated when a period is measured.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            UNLOCKED: if (w_perEv && w_reach)  w_nextState = LOCKED;
            LOCKED:   if (w_perEv && !w_match) w_nextState = UNLOCKED;
            default:  w_nextState = UNLOCKED;
        endcase
    end

    // Publish strobes: period whenever a matching period keeps or gains lock, width at each end while locked.
    always_comb begin
        w_lock      = (r_state == LOCKED);
        w_pubPeriod = w_perEv & w_match & (w_nextState == LOCKED);
        w_pubWidth  = i_end & w_valid & (r_state == LOCKED);
    end

    // Published geometry holds its last value across loss of lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period <= '0;
            r_width  <= '0;
        end else begin
            if (w_pubPeriod) r_period <= w_meas;
            if (w_pubWidth)  r_width  <= w_meas;
        end
    end

    assign o_period = r_period;
    assign o_width  = r_width;
    assign o_lock   = w_lock;
    assign o_ovf    = w_sat;

endmodule

// File: rtl/sync_meter.sv
// sync_meter: video-sync timing meter. Normalises hsync/vsync polarity,
// detects pulse edges, measures both axes and emits a frame strobe once
// both axes are locked. Build macro SYNC_METER_TOL_EN: +/-1 period tolerance.
module sync_meter
    import sync_meter_pkg::*;
#(
    parameter int CNT_W  = 12,
    parameter int LIN_W  = 10,
    parameter int LOCK_N = 2,
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hsync,
    input  logic             vsync,
    output logic [CNT_W-1:0] hperiod,
    output logic [CNT_W-1:0] hwidth,
    output logic [LIN_W-1:0] vperiod,
    output logic [LIN_W-1:0] vwidth,
    output logic             h_lock,
    output logic             v_lock,
    output logic             h_ovf,
    output logic             v_ovf,
    output logic             frame_stb
);

    logic r_hs;
    logic r_hsD;
    logic r_vs;
    logic r_vsD;
    logic r_frameStb;
    logic w_hbeg;
    logic w_hend;
    logic w_vbeg;
    logic w_vend;

    // Register syncs as active-high pulses and keep one cycle of history for edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs  <= 1'b0;
            r_hsD <= 1'b0;
            r_vs  <= 1'b0;
            r_vsD <= 1'b0;
        end else begin
            r_hs  <= hsync ^ ~HS_POL;
            r_hsD <= r_hs;
            r_vs  <= vsync ^ ~VS_POL;
            r_vsD <= r_vs;
        end
    end

    assign w_hbeg = r_hs & ~r_hsD;
    assign w_hend = ~r_hs & r_hsD;
    assign w_vbeg = r_vs & ~r_vsD;
    assign w_vend = ~r_vs & r_vsD;

    // Frame strobe uses lock state as it stood at the vsync begin edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frameStb <= 1'b0;
        end else begin
            r_frameStb <= w_vbeg & h_lock & v_lock;
        end
    end

    sync_axis_meter #(
        .W      (CNT_W),
        .LOCK_N (LOCK_N)
    ) u_hAxis (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_beg    (w_hbeg),
        .i_end    (w_hend),
        .i_tick   (1'b1),
        .o_period (hperiod),
        .o_width  (hwidth),
        .o_lock   (h_lock),
        .o_ovf    (h_ovf)
    );

    // Vertical axis counts lines; a line-start coinciding with vbeg closes the period.
    sync_axis_meter #(
        .W      (LIN_W),
        .LOCK_N (LOCK_N)
    ) u_vAxis (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_beg    (w_vbeg),
        .i_end    (w_vend),
        .i_tick   (w_hbeg),
        .o_period (vperiod),
        .o_width  (vwidth),
        .o_lock   (v_lock),
        .o_ovf    (v_ovf)
    );

    assign frame_stb = r_frameStb;

endmodule
